fwd_hazard_unit: RTL and testbench

Parametrised next-generation operand bypass and hazard controller for the 5-stage pipeline.
- Replaces instruction-pattern bypass with an internal destination-tag scoreboard (X/M/W) fed from decoded D-stage fields.
- Drives X-stage operand muxing and M-stage store-data muxing.
- Generates load-use and multi-cycle mult/div stalls, which the old bypass lacked.
- Sits between decode and the DX/XM latches; the stall output freezes PC, FD, and the D-side inputs.

---
 rtl/fwd_hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand bypass, load-use and mult/div stall control; optional stats via FWD_STATS_EN
module fwd_hazard_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_we,
    input  logic              d_load,
    input  logic              d_md,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_uses_rt,
    input  logic [REG_AW-1:0] x_rs,
    input  logic [REG_AW-1:0] x_rt,
    input  logic [DATA_W-1:0] x_a,
    input  logic [DATA_W-1:0] x_b,
    input  logic [DATA_W-1:0] m_o,
    input  logic [DATA_W-1:0] m_b,
    input  logic [REG_AW-1:0] m_rt,
    input  logic [DATA_W-1:0] w_data,
    output logic              md_ready,
    output logic              stall,
    output logic [DATA_W-1:0] dx_out_a,
    output logic [DATA_W-1:0] dx_out_b,
    output logic [DATA_W-1:0] xm_out_b
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  ldu_cnt,
    output logic [CNT_W-1:0]  md_cnt_stall
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
        logic              md;
    } sb_entry_t;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    localparam int MC_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MC_W-1:0] MD_INIT = MC_W'(MD_LATENCY - 1);

    sb_entry_t sb_x, sb_m, sb_w, d_entry;
    md_state_t md_state;
    logic [MC_W-1:0] md_cnt;
    logic load_use, md_busy, md_start;
    logic fa_m, fa_w, fb_m, fb_w, fs_w;

    // An entry produces a forwardable register value only if it writes a non-zero register
    function automatic logic writer(input sb_entry_t e);
        return e.valid & e.we & (e.rd != '0);
    endfunction

    assign d_entry = '{valid: d_valid, rd: d_rd, we: d_we, load: d_load, md: d_md};

    // Hazard detection: one bubble behind a load, hold X while mult/div is still counting
    always_comb begin
        load_use = writer(sb_x) & sb_x.load &
                   ((d_rs == sb_x.rd) | (d_uses_rt & (d_rt == sb_x.rd)));
        md_busy  = (md_state == MD_BUSY) & (md_cnt != '0);
        md_ready = (md_state == MD_BUSY) & (md_cnt == '0);
        stall    = load_use | md_busy;
        md_start = ~stall & d_valid & d_md;
    end

    // Destination-tag scoreboard advancing with the pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            sb_x <= '0;
            sb_m <= '0;
            sb_w <= '0;
        end else if (!stall) begin
            sb_x <= d_entry;
            sb_m <= sb_x;
            sb_w <= sb_m;
        end else if (md_busy) begin
            sb_m <= '0;
            sb_w <= sb_m;
        end else begin
            sb_x <= '0;
            sb_m <= sb_x;
            sb_w <= sb_m;
        end
    end

    // Mult/div occupancy: counting starts on the edge that moves the op into X, so its
    // first X cycle already sees MD_LATENCY-1 and a latency of 1 never stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (md_start) begin
                        md_state <= MD_BUSY;
                        md_cnt   <= MD_INIT;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != '0) begin
                        md_cnt <= md_cnt - MC_W'(1);
                    end else if (md_start) begin
                        md_cnt <= MD_INIT;
                    end else begin
                        md_state <= MD_IDLE;
                    end
                end
                default: md_state <= MD_IDLE;
            endcase
        end
    end

    // Operand and store-data muxes; a load in M has no data yet so only W may supply it
    always_comb begin
        fa_m = (x_rs == sb_m.rd) & writer(sb_m) & ~sb_m.load;
        fa_w = (x_rs == sb_w.rd) & writer(sb_w);
        fb_m = (x_rt == sb_m.rd) & writer(sb_m) & ~sb_m.load;
        fb_w = (x_rt == sb_w.rd) & writer(sb_w);
        fs_w = (m_rt == sb_w.rd) & writer(sb_w);
        dx_out_a = fa_m ? m_o : (fa_w ? w_data : x_a);
        dx_out_b = fb_m ? m_o : (fb_w ? w_data : x_b);
        xm_out_b = fs_w ? w_data : m_b;
    end

    logic unused_fields;
    assign unused_fields = ^{sb_x.md, sb_m.md, sb_w.load, sb_w.md};

`ifdef FWD_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_cnt      <= '0;
            ldu_cnt      <= '0;
            md_cnt_stall <= '0;
        end else begin
            if (fa_m | fa_w | fb_m | fb_w | fs_w) fwd_cnt <= sat_inc(fwd_cnt);
            if (load_use) ldu_cnt <= sat_inc(ldu_cnt);
            if (md_busy) md_cnt_stall <= sat_inc(md_cnt_stall);
        end
    end
`else
    logic [CNT_W-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and randomized checks of fwd_hazard_unit against an instruction-level model
module tb_fwd_hazard_unit;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 4;

    logic clock = 1'b0;
    logic reset;
    logic d_valid, d_we, d_load, d_md, d_uses_rt;
    logic [AW-1:0] d_rd, d_rs, d_rt, x_rs, x_rt, m_rt;
    logic [DW-1:0] x_a, x_b, m_o, m_b, w_data;
    logic md_ready, stall;
    logic [DW-1:0] dx_out_a, dx_out_b, xm_out_b;

    fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .MD_LATENCY(LAT), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .d_valid(d_valid), .d_rd(d_rd), .d_we(d_we), .d_load(d_load), .d_md(d_md),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rt(d_uses_rt),
        .x_rs(x_rs), .x_rt(x_rt), .x_a(x_a), .x_b(x_b),
        .m_o(m_o), .m_b(m_b), .m_rt(m_rt), .w_data(w_data),
        .md_ready(md_ready), .stall(stall),
        .dx_out_a(dx_out_a), .dx_out_b(dx_out_b), .xm_out_b(xm_out_b)
    );

    always #5 clock = ~clock;

    // Instruction as it sits in a pipeline stage
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
        bit md;
    } instr_t;

    instr_t in_x, in_m, in_w, bubble;
    int x_age;            // cycles the instruction in X has already spent there
    bit exp_stall, exp_busy;
    int errors = 0;
    int checks = 0;

    function automatic bit produces(instr_t i);
        return i.v && i.we && (i.rd != 0);
    endfunction

    // Newest older instruction that already has its result wins; r0 is never forwarded
    function automatic logic [DW-1:0] model_fwd(int addr, logic [DW-1:0] latched, bit use_m);
        if (addr == 0) return latched;
        if (use_m && produces(in_m) && !in_m.ld && in_m.rd == addr) return m_o;
        if (produces(in_w) && in_w.rd == addr) return w_data;
        return latched;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input bit v, input int rd, input bit we, input bit ld, input bit md,
                         input int rs, input int rt, input bit urt);
        d_valid = v; d_rd = AW'(rd); d_we = we; d_load = ld; d_md = md;
        d_rs = AW'(rs); d_rt = AW'(rt); d_uses_rt = urt;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Let inputs settle, then compare every output with the model
    task automatic settle_check();
        bit ldu, rdy;
        #1;
        ldu = produces(in_x) && in_x.ld &&
              (int'(d_rs) == in_x.rd || (d_uses_rt && int'(d_rt) == in_x.rd));
        exp_busy  = in_x.v && in_x.md && (x_age < LAT - 1);
        rdy       = in_x.v && in_x.md && (x_age == LAT - 1);
        exp_stall = ldu || exp_busy;
        check("stall", 32'(stall), 32'(exp_stall));
        check("md_ready", 32'(md_ready), 32'(rdy));
        check("dx_out_a", dx_out_a, model_fwd(int'(x_rs), x_a, 1'b1));
        check("dx_out_b", dx_out_b, model_fwd(int'(x_rt), x_b, 1'b1));
        check("xm_out_b", xm_out_b, model_fwd(int'(m_rt), m_b, 1'b0));
    endtask

    // Clock edge, then move instructions through the model pipeline
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            in_x = bubble; in_m = bubble; in_w = bubble; x_age = 0;
        end else if (!exp_stall) begin
            in_w = in_m; in_m = in_x;
            in_x.v = d_valid; in_x.rd = int'(d_rd); in_x.we = d_we;
            in_x.ld = d_load; in_x.md = d_md;
            x_age = 0;
        end else if (exp_busy) begin
            in_w = in_m; in_m = bubble; x_age++;
        end else begin
            in_w = in_m; in_m = in_x; in_x = bubble;
        end
        #1;
    endtask

    initial begin
        bubble = '{v: 0, rd: 0, we: 0, ld: 0, md: 0};
        in_x = bubble; in_m = bubble; in_w = bubble; x_age = 0;
        reset = 1'b1; nop();
        x_rs = '0; x_rt = '0; m_rt = '0;
        x_a = '0; x_b = '0; m_o = '0; m_b = '0; w_data = '0;
        @(posedge clock); #1;
        tick();
        reset = 1'b0;
        x_rs = 5'd3; x_a = 32'h1234;
        settle_check();
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_md_ready", 32'(md_ready), 32'd0);
        check("reset_latched_a", dx_out_a, 32'h1234);
        tick();

        // Two writers of r3 in M and W: M wins, then W once M drains
        x_rs = '0;
        set_d(1, 3, 1, 0, 0, 0, 0, 0); settle_check(); tick();
        set_d(1, 3, 1, 0, 0, 0, 0, 0); settle_check(); tick();
        nop(); settle_check(); tick();
        x_rs = 5'd3; x_a = 32'h33; m_o = 32'h11; w_data = 32'h22;
        settle_check(); check("m_priority", dx_out_a, 32'h11); tick();
        settle_check(); check("w_forward", dx_out_a, 32'h22); tick();

        // Load-use on r5: single stall cycle, then W supplies the loaded value
        x_rs = '0;
        set_d(1, 5, 1, 1, 0, 0, 0, 0); settle_check(); tick();
        set_d(1, 6, 1, 0, 0, 5, 0, 0); settle_check(); check("ldu_stall", 32'(stall), 32'd1); tick();
        settle_check(); check("ldu_one_cycle", 32'(stall), 32'd0); tick();
        nop(); x_rs = 5'd5; x_a = '0; w_data = 32'hABCD; m_o = 32'hDEAD;
        settle_check(); check("load_w_fwd", dx_out_a, 32'hABCD); tick();

        // Writer of r0 in M is ignored
        x_rs = '0;
        set_d(1, 0, 1, 0, 0, 0, 0, 0); settle_check(); tick();
        nop(); settle_check(); tick();
        x_a = '0; m_o = 32'hFFFF;
        settle_check();
        check("r0_no_fwd", dx_out_a, 32'h0);
        check("r0_no_stall", 32'(stall), 32'd0);
        tick();

        // Mult/div occupies X for LAT cycles
        set_d(1, 8, 1, 0, 1, 0, 0, 0); settle_check(); tick();
        nop();
        for (int c = 1; c <= LAT; c++) begin
            settle_check();
            check("md_stall_seq", 32'(stall), 32'(c < LAT));
            check("md_ready_seq", 32'(md_ready), 32'(c == LAT));
            tick();
        end
        settle_check();
        check("md_done_ready", 32'(md_ready), 32'd0);
        check("md_done_stall", 32'(stall), 32'd0);
        tick();

        // Store in W is not a source; load in W feeds store data
        set_d(1, 7, 0, 0, 0, 0, 0, 0); settle_check(); tick();
        nop(); settle_check(); tick();
        settle_check(); tick();
        x_rt = 5'd7; x_b = 32'h5; w_data = 32'h77;
        settle_check(); check("sw_not_source", dx_out_b, 32'h5); tick();
        x_rt = '0;
        set_d(1, 7, 1, 1, 0, 0, 0, 0); settle_check(); tick();
        nop(); settle_check(); tick();
        settle_check(); tick();
        m_rt = 5'd7; m_b = 32'h1; w_data = 32'h9;
        settle_check(); check("store_data_fwd", xm_out_b, 32'h9); tick();
        m_rt = '0;

        // Reset in the second busy cycle of a mult/div
        set_d(1, 9, 1, 0, 0, 0, 0, 0); settle_check(); tick();
        set_d(1, 8, 1, 0, 1, 0, 0, 0); settle_check(); tick();
        nop(); settle_check(); tick();
        x_rs = 5'd9; x_a = 32'h5A; w_data = 32'h66;
        settle_check(); check("pre_reset_fwd", dx_out_a, 32'h66);
        reset = 1'b1; tick(); reset = 1'b0;
        settle_check();
        check("rst_busy_stall", 32'(stall), 32'd0);
        check("rst_busy_ready", 32'(md_ready), 32'd0);
        check("rst_busy_fwd", dx_out_a, 32'h5A);
        tick();
        for (int c = 0; c < LAT + 1; c++) begin
            settle_check();
            check("rst_no_ready", 32'(md_ready), 32'd0);
            tick();
        end

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_d($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
            x_rs = AW'($urandom_range(0, 3)); x_rt = AW'($urandom_range(0, 3));
            m_rt = AW'($urandom_range(0, 3));
            x_a = $urandom; x_b = $urandom; m_o = $urandom; m_b = $urandom; w_data = $urandom;
            settle_check();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
